// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display peripherals: register offsets,
// CTRL field positions, the hex glyph table and idle pin levels.
package seg_display_pkg;

  localparam logic [31:0] DATA_OFS = 32'h0;
  localparam logic [31:0] CTRL_OFS = 32'h4;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DP_LSB    = 1;
  localparam int CTRL_BLANK_LSB = 4;
  localparam int CTRL_DUTY_LSB  = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [2:0] SEL_NONE  = 3'b111;

  typedef struct packed {
    logic [2:0] blank;
    logic [2:0] dp;
    logic       en;
  } ctrl_t;

  // Active-low g..a patterns, entry 15 first down to entry 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment (g..a) pattern.
module hex_to_seg
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped 3-digit multiplexed seven-segment controller (DATA and CTRL registers).
// Optional macro SEG_BRIGHTNESS_EN adds a PWM duty field in CTRL[10:8].
//
// state | meaning
// DIG0  | digit 0 (least significant) selected
// DIG1  | digit 1 selected
// DIG2  | digit 2 selected
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic [2:0]  sel,
  output logic [7:0]  seg
);

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;

  localparam int          CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [31:0] DATA_ADDR = BASE_ADDR + DATA_OFS;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFS;

  logic [11:0]      data_q;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [2:0]       sel_q;
  logic [7:0]       seg_q;
  logic             hit_data;
  logic             hit_ctrl;
  logic [31:0]      ctrl_rd;
  logic [2:0]       dig_oh;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             digit_on;
  logic             unused_bits;

  assign hit_data    = (Address[31:2] == DATA_ADDR[31:2]);
  assign hit_ctrl    = (Address[31:2] == CTRL_ADDR[31:2]);
  assign unused_bits = ^{Address[1:0], Write_data[31:12]};

`ifdef SEG_BRIGHTNESS_EN
  logic [2:0] duty_q;
  logic [2:0] pwm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      if (MemWrite && hit_ctrl) duty_q <= Write_data[CTRL_DUTY_LSB +: 3];
      pwm_q <= ctrl_q.en ? pwm_q + 3'd1 : 3'd0;
    end
  end

  assign digit_on = (pwm_q <= duty_q);
  assign ctrl_rd  = {21'b0, duty_q, 1'b0, ctrl_q};
`else
  assign digit_on = 1'b1;
  assign ctrl_rd  = {25'b0, ctrl_q};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (MemWrite) begin
      if (hit_data) data_q <= Write_data[11:0];
      if (hit_ctrl) begin
        ctrl_q.en    <= Write_data[CTRL_EN_BIT];
        ctrl_q.dp    <= Write_data[CTRL_DP_LSB +: 3];
        ctrl_q.blank <= Write_data[CTRL_BLANK_LSB +: 3];
      end
    end
  end

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (hit_data)      Read_data = {20'b0, data_q};
      else if (hit_ctrl) Read_data = ctrl_rd;
    end
  end

  assign dig_oh = 3'b001 << idx_q;

  always_comb begin
    case (idx_q)
      DIG1:    nibble = data_q[7:4];
      DIG2:    nibble = data_q[11:8];
      default: nibble = data_q[3:0];
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_n  (glyph)
  );

  // Pins are registered from the current state, so they trail the scan state by one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= DIG0;
      sel_q <= SEL_NONE;
      seg_q <= SEG_BLANK;
    end else if (!ctrl_q.en) begin
      cnt_q <= '0;
      idx_q <= DIG0;
      sel_q <= SEL_NONE;
      seg_q <= SEG_BLANK;
    end else begin
      if (digit_on) begin
        sel_q <= ~dig_oh;
        seg_q <= (|(ctrl_q.blank & dig_oh)) ? SEG_BLANK : {~(|(ctrl_q.dp & dig_oh)), glyph};
      end else begin
        sel_q <= SEL_NONE;
        seg_q <= SEG_BLANK;
      end
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        case (idx_q)
          DIG0:    idx_q <= DIG1;
          DIG1:    idx_q <= DIG2;
          default: idx_q <= DIG0;
        endcase
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl (SCAN_DIV=4) with a cycle-count reference model.
module tb_seg_display_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0010;
  localparam int          SD   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic [2:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data;
  logic [31:0] m_ctrl;
  int          steps;

  always #5 clk = ~clk;

  seg_display_ctrl #(.BASE_ADDR(BASE), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .sel        (sel),
    .seg        (seg)
  );

  function automatic logic [7:0] hex8(input logic [3:0] n);
    case (n)
      4'h0: hex8 = 8'hC0;  4'h1: hex8 = 8'hF9;  4'h2: hex8 = 8'hA4;  4'h3: hex8 = 8'hB0;
      4'h4: hex8 = 8'h99;  4'h5: hex8 = 8'h92;  4'h6: hex8 = 8'h82;  4'h7: hex8 = 8'hF8;
      4'h8: hex8 = 8'h80;  4'h9: hex8 = 8'h90;  4'hA: hex8 = 8'h88;  4'hB: hex8 = 8'h83;
      4'hC: hex8 = 8'hC6;  4'hD: hex8 = 8'hA1;  4'hE: hex8 = 8'h86;  default: hex8 = 8'h8E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check the load, advance the model, check pins after the edge.
  task automatic tick(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic [2:0]  exp_sel;
    logic [7:0]  exp_seg;
    int          d;
    MemRead = rd; MemWrite = wr; Address = addr; Write_data = wd;
    #1;
    exp_rd = 32'h0;
    if (rd && addr[31:2] == BASE[31:2])                exp_rd = m_data;
    else if (rd && addr[31:2] == (BASE + 32'd4) >> 2)  exp_rd = m_ctrl;
    chk("read_data", Read_data, exp_rd);
    if (m_ctrl[0]) begin
      d = (steps / SD) % 3;
      steps++;
      exp_sel = ~(3'b001 << d);
      if (m_ctrl[4 + d]) exp_seg = 8'hFF;
      else exp_seg = hex8(m_data[4*d +: 4]) & (m_ctrl[1 + d] ? 8'h7F : 8'hFF);
    end else begin
      steps   = 0;
      exp_sel = 3'b111;
      exp_seg = 8'hFF;
    end
    if (wr && addr[31:2] == BASE[31:2])               m_data = wd & 32'h0000_0FFF;
    if (wr && addr[31:2] == (BASE + 32'd4) >> 2)      m_ctrl = wd & 32'h0000_007F;
    @(posedge clk);
    @(negedge clk);
    chk("sel", {29'b0, sel}, {29'b0, exp_sel});
    chk("seg", {24'b0, seg}, {24'b0, exp_seg});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; Address = '0; Write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;
    m_data = '0; m_ctrl = '0; steps = 0;
    #1;
    chk("reset_sel", {29'b0, sel}, 32'h7);
    chk("reset_seg", {24'b0, seg}, 32'hFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    idle(2);
    tick(1'b1, 1'b0, BASE, 32'h0);
    tick(1'b1, 1'b0, BASE + 32'd4, 32'h0);

    tick(1'b0, 1'b1, BASE, 32'hFFFF_F210);
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h1);
    idle(24);

    tick(1'b0, 1'b1, BASE + 32'd4, 32'h3);
    idle(12);
    tick(1'b1, 1'b0, BASE + 32'd4, 32'h0);

    tick(1'b0, 1'b1, BASE + 32'd4, 32'h21);
    idle(12);

    idle(2);
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    idle(3);
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h1);
    idle(14);

    tick(1'b1, 1'b1, BASE, 32'h0000_0ABC);
    tick(1'b1, 1'b0, BASE, 32'h0);
    idle(12);

    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b1, BASE, $urandom);
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[0] = 1'b1;
      tick($urandom_range(0, 1) == 1, 1'b1, BASE + 32'd4, r);
      idle($urandom_range(1, 15));
      tick(1'b1, 1'b0, ($urandom_range(0, 1) == 1) ? BASE + 32'd4 : BASE, 32'h0);
    end

    tick(1'b0, 1'b1, BASE + 32'd4, 32'h1);
    tick(1'b0, 1'b1, BASE + 32'd8, 32'hFFFF_FFFF);
    tick(1'b1, 1'b0, BASE, 32'h0);
    tick(1'b1, 1'b0, BASE + 32'd4, 32'h0);
    idle(5);

    MemRead = 1'b1; MemWrite = 1'b0; Address = BASE + 32'd4;
    #3 reset = 1'b1;
    #1;
    chk("async_reset_sel", {29'b0, sel}, 32'h7);
    chk("async_reset_seg", {24'b0, seg}, 32'hFF);
    chk("async_reset_ctrl", Read_data, 32'h0);
    m_data = '0; m_ctrl = '0; steps = 0;
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    tick(1'b1, 1'b0, BASE, 32'h0);
    tick(1'b1, 1'b0, BASE + 32'd4, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
